// File: rtl/kuznechik_pkg.sv
// Shared Kuznechik definitions: byte geometry, round-stage FSM encoding and the
// pi / pi^-1 substitution tables used by the datapath and the reference model.
package kuznechik_pkg;

    localparam int BYTE_W      = 8;
    localparam int BLOCK_BYTES = 16;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef byte_t sbox_t [256];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam sbox_t PI = '{
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };

    // pi is a bijection, so its inverse is derived at elaboration instead of typed by hand.
    function automatic sbox_t invert_sbox(input sbox_t fwd);
        sbox_t inv;
        for (int i = 0; i < 256; i++) begin
            inv[fwd[i]] = byte_t'(i);
        end
        return inv;
    endfunction

    localparam sbox_t PI_INV = invert_sbox(PI);

endpackage

// File: rtl/s_box_table.sv
// Combinational Kuznechik byte substitution; INVERSE selects pi^-1 instead of pi.
module s_box_table
    import kuznechik_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  logic [7:0] input_bytes,
    output logic [7:0] output_bytes
);

    assign output_bytes = INVERSE ? PI_INV[input_bytes] : PI[input_bytes];

endmodule

// File: rtl/xs_convertion.sv
// Kuznechik round front-end: key addition and byte substitution over a 128-bit
// word, one byte per clock, with the level enable / finish handshake of the L stage.
module xs_convertion
    import kuznechik_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [127:0] input_word,
    input  logic [127:0] round_key,
    output logic [127:0] output_word,
    output logic         finish_convertion
);

    state_t state, next_state;
    logic [3:0] counter;
    logic [BLOCK_BYTES-1:0][BYTE_W-1:0] data_reg, key_reg;
    byte_t sbox_in, sbox_out, new_byte;
    logic capture, shift, load_out;

    // Encrypt keys before the table, decrypt keys after it.
    assign sbox_in  = INVERSE ? data_reg[BLOCK_BYTES-1] : (data_reg[BLOCK_BYTES-1] ^ key_reg[BLOCK_BYTES-1]);
    assign new_byte = INVERSE ? (sbox_out ^ key_reg[BLOCK_BYTES-1]) : sbox_out;

    s_box_table #(.INVERSE(INVERSE)) u_s_box_table (
        .input_bytes  (sbox_in),
        .output_bytes (sbox_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (enable) next_state = RUN;
            RUN:     if (counter == 4'd15) next_state = DONE;
            DONE:    if (!enable) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        capture  = (state == IDLE) && enable;
        shift    = (state == RUN);
        load_out = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter           <= '0;
            data_reg          <= '0;
            key_reg           <= '0;
            output_word       <= '0;
            finish_convertion <= 1'b0;
        end else begin
            if (state == IDLE) begin
                counter           <= '0;
                finish_convertion <= 1'b0;
            end
            if (capture) begin
                data_reg <= input_word;
                key_reg  <= round_key;
            end
            // Byte 15 is consumed and its result re-enters at byte 0; the key just rotates.
            if (shift) begin
                data_reg <= {data_reg[BLOCK_BYTES-2:0], new_byte};
                key_reg  <= {key_reg[BLOCK_BYTES-2:0], key_reg[BLOCK_BYTES-1]};
                if (counter != 4'd15) counter <= counter + 4'd1;
            end
            if (load_out) begin
                output_word       <= data_reg;
                finish_convertion <= enable;
            end
        end
    end

endmodule

// File: tb/tb_xs_convertion.sv
// Bench for xs_convertion: encrypt and decrypt builds side by side on shared
// stimulus, checked every cycle against a transaction-level model plus literal vectors.
module tb_xs_convertion;
    import kuznechik_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [127:0] din, key;
    logic [127:0] dout0, dout1;
    logic         fin0, fin1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [127:0] VA = 128'hffeeddccbbaa99881122334455667700;
    localparam logic [127:0] VB = 128'hb66cd8887d38e8d77765aeea0c9a7efc;

    always #5 clk = ~clk;

    xs_convertion #(.INVERSE(1'b0)) u_enc (
        .clk(clk), .rst_n(rst_n), .enable(enable), .input_word(din), .round_key(key),
        .output_word(dout0), .finish_convertion(fin0)
    );

    xs_convertion #(.INVERSE(1'b1)) u_dec (
        .clk(clk), .rst_n(rst_n), .enable(enable), .input_word(din), .round_key(key),
        .output_word(dout1), .finish_convertion(fin1)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    // Whole-word result of one conversion, straight from the byte-wise definition.
    function automatic logic [127:0] ref_xs(input bit inv, input logic [127:0] d, input logic [127:0] k);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = inv ? (PI_INV[d[8*i +: 8]] ^ k[8*i +: 8]) : PI[d[8*i +: 8] ^ k[8*i +: 8]];
        end
        return r;
    endfunction

    // Transaction model: a conversion starts on an edge with enable, its result lands 17 edges later.
    bit           m_busy;
    int           m_age;
    logic [127:0] m_res0, m_res1, m_out0, m_out1;
    logic         m_fin;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_age <= 0; m_fin <= 1'b0;
            m_res0 <= '0; m_res1 <= '0; m_out0 <= '0; m_out1 <= '0;
        end else if (!m_busy) begin
            m_fin <= 1'b0;
            if (enable) begin
                m_busy <= 1'b1;
                m_age  <= 0;
                m_res0 <= ref_xs(1'b0, din, key);
                m_res1 <= ref_xs(1'b1, din, key);
            end
        end else if (m_age < 16) begin
            m_age <= m_age + 1;
        end else begin
            m_out0 <= m_res0;
            m_out1 <= m_res1;
            m_fin  <= enable;
            if (!enable) m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("cyc_fin_enc", {127'd0, fin0}, {127'd0, m_fin});
        chk("cyc_out_enc", dout0, m_out0);
        chk("cyc_fin_dec", {127'd0, fin1}, {127'd0, m_fin});
        chk("cyc_out_dec", dout1, m_out1);
    end

    task automatic start(input logic [127:0] d, input logic [127:0] k);
        @(negedge clk);
        din = d; key = k; enable = 1'b1;
    endtask

    task automatic wait_fin(output int n);
        n = 0;
        while (fin0 !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) chk("finish_timeout", 128'd0, 128'd1);
    endtask

    task automatic finish_op();
        @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int  n;
        bit  seen;
        rst_n = 1'b0; enable = 1'b0; din = '0; key = '0;
        repeat (2) @(negedge clk);
        #2;
        chk("reset_out_enc", dout0, '0);
        chk("reset_fin_enc", {127'd0, fin0}, '0);
        chk("reset_out_dec", dout1, '0);
        @(negedge clk);
        rst_n = 1'b1;

        start('0, '0);
        wait_fin(n);
        chk("latency_zero", 128'(n - 1), 128'd17);
        chk("zero_vec_enc", dout0, {16{8'hFC}});
        chk("zero_vec_dec", dout1, {16{8'hA5}});
        finish_op();

        start(VA, '0);
        wait_fin(n);
        chk("enc_vec", dout0, VB);
        finish_op();

        start(VB, '0);
        wait_fin(n);
        chk("dec_vec", dout1, VA);
        finish_op();

        start('0, VA);
        wait_fin(n);
        chk("enc_key_vec", dout0, VB);
        finish_op();

        start(VB, VA);
        wait_fin(n);
        chk("dec_key_vec", dout1, '0);
        finish_op();

        // One-cycle enable pulse with inputs scrambled after capture.
        start('0, '0);
        @(negedge clk);
        enable = 1'b0; din = ~VA; key = {4{32'hdeadbeef}};
        seen = 1'b0;
        repeat (24) begin
            @(posedge clk); #1;
            if (fin0 === 1'b1 || fin1 === 1'b1) seen = 1'b1;
        end
        chk("pulse_no_finish", {127'd0, seen}, '0);
        chk("pulse_out_enc", dout0, {16{8'hFC}});

        start(VA, '0);
        wait_fin(n);
        chk("latency_after_pulse", 128'(n - 1), 128'd17);
        chk("enc_after_pulse", dout0, VB);

        // Drop enable for a single edge at DONE, then restart immediately.
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        din = VB; key = '0; enable = 1'b1;
        wait_fin(n);
        chk("latency_back2back", 128'(n - 1), 128'd17);
        chk("dec_back2back", dout1, VA);
        finish_op();

        // Asynchronous reset in the middle of RUN.
        start(VA, '0);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_out_enc", dout0, '0);
        chk("midreset_fin_enc", {127'd0, fin0}, '0);
        chk("midreset_out_dec", dout1, '0);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start('0, '0);
        wait_fin(n);
        chk("post_reset_latency", 128'(n - 1), 128'd17);
        chk("post_reset_enc", dout0, {16{8'hFC}});
        chk("post_reset_dec", dout1, {16{8'hA5}});
        finish_op();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/xs_convertion.md
Name: xs_convertion

Overview:
- Round front-end of the Kuznechik datapath, paired with the L stage.
- Combines key addition (X) and byte substitution (S / S^-1) on a 128-bit word, one byte per clock.
- Encrypt build (INVERSE=0) computes pi(input ^ key) and feeds the L stage.
- Decrypt build (INVERSE=1) computes pi^-1(input) ^ key and consumes the L^-1 stage output.
- Uses the same level enable / finish handshake as the L stage, so the two chain directly in the round controller.

Parameters:
- INVERSE, 0, selects the function: 0 = S after X (table pi); 1 = X after S^-1 (table pi^-1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active low
- enable  input  1  1 = start conversion; held high until finish seen
- input_word  input  128  data word, byte 15 = bits [127:120]
- round_key  input  128  round key, same byte order
- output_word  output reg  128  converted word
- finish_convertion  output reg  1  1 = output_word valid; held until enable drops

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE, counter = 0.
  - output_word = 0, finish_convertion = 0, data/key shift registers cleared.
  - Reset mid-operation aborts the operation; no partial result is ever written to output_word.
- State IDLE:
  - finish_convertion <= 0, counter <= 0.
  - If enable = 1: capture input_word into data_reg[15:0] and round_key into key_reg[15:0], then go to RUN.
- State RUN (exactly 16 cycles, counter 0..15):
  - Operating byte = data_reg[15] with key_reg[15].
  - INVERSE=0: new byte = pi(data_reg[15] ^ key_reg[15]).
  - INVERSE=1: new byte = pi_inv(data_reg[15]) ^ key_reg[15].
  - Both registers rotate left by one byte; the new byte enters data_reg[0], and key_reg[15] wraps into key_reg[0].
  - After 16 rotations every byte is back in its original position.
  - When counter = 15, go to DONE; otherwise counter increments.
- State DONE:
  - output_word <= {data_reg[15..0]}, finish_convertion <= 1 (both registered; first visible in the cycle after entering DONE).
  - If enable = 0 on the same edge: go to IDLE; finish_convertion stays 0 and output_word is still loaded.
  - Otherwise remain in DONE, holding output_word and finish_convertion.
- Latency: capturing edge E0, processing edges E1..E16, finish_convertion high after edge E17.
- Boundary conditions:
  - enable falling during RUN is ignored; the conversion completes, finish_convertion is never asserted, and output_word is still updated at DONE.
  - enable held high after returning to IDLE starts a new conversion on the next edge.
  - output_word keeps the last result until the next DONE; it does not clear in IDLE.
  - input_word and round_key changes after E0 have no effect on the current operation.
- Arithmetic: all XOR is bitwise over 8 bits; no carries, no width growth.

Decomposition:
- Shared package (kuznechik_pkg):
  - BYTE_W = 8, BLOCK_BYTES = 16.
  - State encodings IDLE/RUN/DONE.
  - The pi and pi^-1 table contents as constant arrays, also used by the bench reference model.
- Sub-module s_box_table:
  - Purely combinational byte lookup, parameter INVERSE, ports input_bytes[7:0] and output_bytes[7:0].
  - Instantiated once, on data_reg[15] path.

Test Plan:
- INVERSE=0, input = 0, key = 0 -> output_word = 0xFCFC...FC (16 bytes), finish_convertion high exactly 17 cycles after the enable edge.
- INVERSE=0, input = ffeeddccbbaa99881122334455667700, key = 0 -> b66cd8887d38e8d77765aeea0c9a7efc.
- INVERSE=1, input = b66cd8887d38e8d77765aeea0c9a7efc, key = 0 -> ffeeddccbbaa99881122334455667700.
- INVERSE=0, input = 0, key = ffeeddccbbaa99881122334455667700 -> b66cd8887d38e8d77765aeea0c9a7efc.
- enable pulsed 1 cycle, then low -> finish_convertion never asserted; output_word updated at the DONE edge; FSM back in IDLE.
- rst_n low at RUN cycle 8 -> immediate IDLE, outputs 0; after release, a fresh enable yields the correct result with no stale bytes.
